// File: rtl/captura_jogada.sv
// captura_jogada: player-side move capture for the game control unit.
// While a move is requested, it debounces the 3x3 cell buttons and checks the
// press. A stable one-hot press on a free cell is encoded as a 0..8 index and
// announced with a one-cycle tem_jogada pulse. Any other stable press gives a
// one-cycle jogada_invalida pulse. The unit then waits for a debounced
// release, so a held button can never produce a second move.
module captura_jogada #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CICLOS) + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [8:0] botoes,
    input  logic [8:0] ocupadas,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       jogada_invalida,
    output logic [3:0] db_estado
);

    // The state codes double as the db_estado debug codes.
    typedef enum logic [3:0] {
        ESPERA   = 4'd0,
        FILTRA   = 4'd1,
        EMITE    = 4'd2,
        INVALIDA = 4'd3,
        SOLTA    = 4'd4
    } estado_t;

    // Terminal count shared by press filtering and release filtering.
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

    estado_t          estado_q;
    logic [CNT_W-1:0] cont_q;
    logic [8:0]       amostra_q;
    logic [3:0]       jogada_q;
    logic             tem_jogada_q;
    logic             jogada_invalida_q;

    // Properties of the held sample, used only on the deciding edge.
    logic [3:0]       n_bits;
    logic [3:0]       indice;
    logic             um_so;
    logic             conflito;

    // Count the bits of the sample and locate the set bit (meaningful when one-hot).
    always_comb begin
        n_bits = '0;
        indice = '0;
        for (int i = 0; i < 9; i++) begin
            if (amostra_q[i]) begin
                n_bits = n_bits + 4'd1;
                indice = 4'(i);
            end
        end
    end

    assign um_so    = (n_bits == 4'd1);
    assign conflito = |(amostra_q & ocupadas);

    // Capture FSM; the pulses and jogada are registered here with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q          <= ESPERA;
            cont_q            <= '0;
            amostra_q         <= '0;
            jogada_q          <= '0;
            tem_jogada_q      <= 1'b0;
            jogada_invalida_q <= 1'b0;
        end else begin
            // Pulses last one cycle; the EMITE/INVALIDA entries below re-raise them.
            tem_jogada_q      <= 1'b0;
            jogada_invalida_q <= 1'b0;
            case (estado_q)
                ESPERA: begin
                    // Presses are only looked at while a move is requested.
                    if (habilita && (botoes != '0)) begin
                        amostra_q <= botoes;
                        cont_q    <= '0;
                        estado_q  <= FILTRA;
                    end
                end
                FILTRA: begin
                    if (!habilita) begin
                        estado_q <= ESPERA;
                    end else if (botoes == '0) begin
                        // Contact bounced open: start over from idle.
                        estado_q <= ESPERA;
                    end else if (botoes != amostra_q) begin
                        // Pattern changed: restart filtering on the new pattern.
                        amostra_q <= botoes;
                        cont_q    <= '0;
                    end else if (cont_q == CNT_FIM) begin
                        // Stable long enough: decide with the current occupancy.
                        if (!um_so || conflito) begin
                            estado_q          <= INVALIDA;
                            jogada_invalida_q <= 1'b1;
                        end else begin
                            estado_q     <= EMITE;
                            tem_jogada_q <= 1'b1;
                            jogada_q     <= indice;
                        end
                    end else begin
                        cont_q <= cont_q + CNT_W'(1);
                    end
                end
                EMITE, INVALIDA: begin
                    // The pulse is visible in this cycle; then wait for release.
                    cont_q   <= '0;
                    estado_q <= SOLTA;
                end
                SOLTA: begin
                    // habilita is ignored here so a held button cannot play twice.
                    if (botoes != '0) begin
                        cont_q <= '0;
                    end else if (cont_q == CNT_FIM) begin
                        estado_q <= ESPERA;
                    end else begin
                        cont_q <= cont_q + CNT_W'(1);
                    end
                end
                default: begin
                    estado_q <= ESPERA;
                end
            endcase
        end
    end

    assign jogada          = jogada_q;
    assign tem_jogada      = tem_jogada_q;
    assign jogada_invalida = jogada_invalida_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada with a short debounce. A behavioural model built
// on run lengths of stable input patterns predicts each pulse (cycle, kind,
// cell) into a scoreboard; a negedge monitor pops and compares whenever the
// DUT pulses. Directed cases also check the debug state sequence.
module tb_captura_jogada;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [8:0] botoes;
    logic [8:0] ocupadas;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       jogada_invalida;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    captura_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .botoes          (botoes),
        .ocupadas        (ocupadas),
        .jogada          (jogada),
        .tem_jogada      (tem_jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    typedef struct {
        int cyc;
        bit valida;
        int jog;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_en  = 1'b0;

    // Reference model: a move is decided once the same nonzero pattern has
    // been seen with habilita high on D+1 consecutive edges while armed.
    // After a decision one edge is spent pulsing, then D consecutive
    // released edges re-arm the unit.
    bit         armed   = 1'b1;
    bit         skip    = 1'b0;
    int         run     = 0;
    int         zeros   = 0;
    logic [8:0] run_val = '0;
    int         jog_ref = 0;
    exp_t       em;

    initial forever begin
        @(posedge clock);
        cyc++;
        if (reset) begin
            armed = 1'b1; skip = 1'b0; run = 0; zeros = 0; jog_ref = 0;
        end else if (skip) begin
            skip = 1'b0; zeros = 0;
        end else if (!armed) begin
            zeros = (botoes == 9'd0) ? zeros + 1 : 0;
            if (zeros == D) begin
                armed = 1'b1; run = 0;
            end
        end else if (!habilita || botoes == 9'd0) begin
            run = 0;
        end else begin
            if (run > 0 && botoes == run_val) run++;
            else begin
                run = 1; run_val = botoes;
            end
            if (run == D + 1) begin
                em.cyc = cyc;
                if ($countones(run_val) == 1 && (run_val & ocupadas) == 9'd0) begin
                    em.valida = 1'b1;
                    for (int i = 0; i < 9; i++) if (run_val[i]) jog_ref = i;
                end else begin
                    em.valida = 1'b0;
                end
                em.jog = jog_ref;
                sb.push_back(em);
                armed = 1'b0; skip = 1'b1; run = 0; zeros = 0;
            end
        end
    end

    // Monitor: compares pulses against the scoreboard and jogada against the model.
    exp_t mm;
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            n_tests++;
            if (tem_jogada && jogada_invalida) begin
                n_fail++;
                $display("FAIL both_pulses: cyc %0d tem=1 inv=1, required at most one", cyc);
            end
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_tests++; n_fail++;
                $display("FAIL missed_pulse: expected pulse at cyc %0d not seen (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (tem_jogada || jogada_invalida) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: cyc %0d tem=%0b inv=%0b, required none", cyc, tem_jogada, jogada_invalida);
                end else begin
                    mm = sb.pop_front();
                    if (mm.cyc != cyc || mm.valida != tem_jogada || 4'(mm.jog) !== jogada) begin
                        n_fail++;
                        $display("FAIL pulse: got cyc %0d tem=%0b jogada=%0d, required cyc %0d tem=%0b jogada=%0d",
                                 cyc, tem_jogada, jogada, mm.cyc, mm.valida, mm.jog);
                    end
                end
            end
            n_tests++;
            if (jogada !== 4'(jog_ref)) begin
                n_fail++;
                $display("FAIL jogada_held: cyc %0d got %0d required %0d", cyc, jogada, jog_ref);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, want);
        end
    endtask

    // Drive inputs, advance one edge, then check db_estado unless exp_st < 0.
    task automatic stepc(input logic h, input logic [8:0] b, input logic [8:0] o, input int exp_st);
        habilita = h; botoes = b; ocupadas = o;
        @(posedge clock);
        @(negedge clock);
        if (exp_st >= 0) chk("estado", int'(db_estado), exp_st);
    endtask

    task automatic press(input logic [8:0] b, input logic [8:0] o, input int last_st);
        for (int i = 0; i < 4; i++) stepc(1'b1, b, o, 1);
        stepc(1'b1, b, o, last_st);
        stepc(1'b1, b, o, 4);
    endtask

    task automatic release_all(input logic [8:0] o);
        for (int i = 0; i < 3; i++) stepc(1'b1, 9'd0, o, 4);
        stepc(1'b1, 9'd0, o, 0);
    endtask

    initial begin
        logic [8:0] b, o;
        logic       h;
        int         len, r;
        reset = 1'b1; habilita = 1'b0; botoes = '0; ocupadas = '0;
        stepc(1'b0, 9'd0, 9'd0, -1);
        stepc(1'b0, 9'd0, 9'd0, -1);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_jogada", int'(jogada), 0);
        chk("rst_tem", int'(tem_jogada), 0);
        chk("rst_inv", int'(jogada_invalida), 0);

        // Clean press of the centre cell: 1,1,1,1,2,4.
        press(9'h010, 9'd0, 2);
        stepc(1'b1, 9'h010, 9'd0, 4);
        release_all(9'd0);

        // Bounce, then stable: timing restarts at the last re-entry.
        stepc(1'b1, 9'h010, 9'd0, 1);
        stepc(1'b1, 9'h000, 9'd0, 0);
        press(9'h010, 9'd0, 2);
        release_all(9'd0);

        // Two cells at once: invalid, jogada stays 4.
        press(9'h005, 9'd0, 3);
        release_all(9'd0);
        chk("jogada_keep", int'(jogada), 4);

        // Occupied cell rejected, then a free cell accepted.
        press(9'h100, 9'h100, 3);
        release_all(9'h100);
        press(9'h080, 9'h100, 2);
        release_all(9'h100);
        chk("jogada_7", int'(jogada), 7);

        // Long hold: exactly one move, stays in release wait.
        press(9'h001, 9'd0, 2);
        for (int i = 0; i < 24; i++) stepc(1'b1, 9'h001, 9'd0, 4);
        release_all(9'd0);

        // Presses without habilita are ignored.
        for (int i = 0; i < 6; i++) stepc(1'b0, 9'h001, 9'd0, 0);

        // Reset while filtering at counter 2.
        for (int i = 0; i < 3; i++) stepc(1'b1, 9'h001, 9'd0, 1);
        reset = 1'b1;
        stepc(1'b1, 9'h001, 9'd0, 0);
        reset = 1'b0;
        chk("rstf_jogada", int'(jogada), 0);
        chk("rstf_tem", int'(tem_jogada), 0);
        chk("rstf_inv", int'(jogada_invalida), 0);
        stepc(1'b1, 9'h000, 9'd0, 0);

        // habilita drops while filtering.
        stepc(1'b1, 9'h002, 9'd0, 1);
        stepc(1'b1, 9'h002, 9'd0, 1);
        stepc(1'b0, 9'h002, 9'd0, 0);
        stepc(1'b0, 9'h000, 9'd0, 0);

        // Randomized segments of held patterns.
        for (int s = 0; s < 1500; s++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 9'd0;
            else if (r < 8) b = 9'(1 << $urandom_range(0, 8));
            else            b = 9'($urandom);
            h   = ($urandom_range(0, 9) != 0);
            o   = 9'($urandom) & 9'($urandom);
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 59) == 0) reset = 1'b1;
            for (int i = 0; i < len; i++) begin
                stepc(h, b, o, -1);
                reset = 1'b0;
            end
        end

        reset = 1'b0;
        for (int i = 0; i < 12; i++) stepc(1'b0, 9'd0, 9'd0, -1);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
